axis_pkt_framer: RTL

- Upstream feeder for the 4-input AXI-Stream packet mux; one instance per mux input.
- Converts a continuous 64-bit word stream with no tlast into bounded packets for the mux.
- A packet closes on any of three events: configured length reached, inactivity timeout, or explicit flush.
- The mux relies on every packet ending in tlast; this block guarantees no packet stays open indefinitely.

---
 rtl/axis_pkt_pkg.sv | 8 +
 rtl/axis_pkt_framer_tmo.sv | 48 ++++
 rtl/axis_pkt_framer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/axis_pkt_pkg.sv
// Shared widths, constants and default parameters for the AXI-Stream packet framer.
package axis_pkt_pkg;
  localparam int AXIS_DW = 64;
  localparam int AXIS_KW = 8;
  localparam logic [AXIS_KW-1:0] KEEP_FULL = 8'hFF;
  localparam int LEN_BITS_DEF = 12;
  localparam int TMO_BITS_DEF = 16;
endpackage

// File: rtl/axis_pkt_framer_tmo.sv
// Idle timer for the framer hold register: flags a timeout close and keeps a saturating count of them.
module axis_pkt_framer_tmo
  import axis_pkt_pkg::*;
#(
  parameter int TMO_BITS = TMO_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [TMO_BITS-1:0] cfg_timeout,
  input  logic                accept,
  input  logic                armed,
  output logic                tmo_hit,
  output logic [15:0]         stat_tmo_cnt
);

  logic [TMO_BITS-1:0] idle_q, idle_d;
  logic [15:0]         tmo_cnt_q, tmo_cnt_d;
  logic                enable;

  assign enable = armed && (cfg_timeout != '0);
  // >= rather than == so a timeout lowered mid-count still closes the packet
  assign tmo_hit = enable && !accept && (idle_q >= cfg_timeout);
  assign stat_tmo_cnt = tmo_cnt_q;

  always_comb begin
    idle_d    = idle_q;
    tmo_cnt_d = tmo_cnt_q;
    if (accept || tmo_hit || !enable) begin
      idle_d = '0;
    end else begin
      idle_d = idle_q + TMO_BITS'(1);
    end
    if (tmo_hit && (tmo_cnt_q != 16'hFFFF)) begin
      tmo_cnt_d = tmo_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q    <= '0;
      tmo_cnt_q <= '0;
    end else begin
      idle_q    <= idle_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

endmodule

// File: rtl/axis_pkt_framer.sv
// Cuts a tlast-less 64-bit stream into packets closed by length, idle timeout or flush.
// Optional AXIS_PKT_FRAMER_KEEPCLOSE_EN: a partial word (tkeep != all ones) also closes the packet.
module axis_pkt_framer
  import axis_pkt_pkg::*;
#(
  parameter int LEN_BITS = LEN_BITS_DEF,
  parameter int TMO_BITS = TMO_BITS_DEF
) (
  input  logic                s_axis_clk,
  input  logic                s_arstn,
  input  logic [LEN_BITS-1:0] cfg_pkt_len,
  input  logic [TMO_BITS-1:0] cfg_timeout,
  input  logic                flush,
  input  logic [AXIS_DW-1:0]  s_axis_tdata,
  input  logic [AXIS_KW-1:0]  s_axis_tkeep,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [AXIS_DW-1:0]  m_axis_tdata,
  output logic [AXIS_KW-1:0]  m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [31:0]         stat_pkt_cnt,
  output logic [15:0]         stat_tmo_cnt
);

  logic [AXIS_DW-1:0]  h_data_q, h_data_d, o_data_q, o_data_d;
  logic [AXIS_KW-1:0]  h_keep_q, h_keep_d, o_keep_q, o_keep_d;
  logic                h_vld_q, h_vld_d, h_last_q, h_last_d;
  logic                o_vld_q, o_vld_d, o_last_q, o_last_d;
  logic [LEN_BITS-1:0] wcnt_q, wcnt_d, len_q, len_d, eff_len;
  logic [31:0]         pkt_cnt_q, pkt_cnt_d;
  logic                o_free, accept, move_h, new_last, keep_close, tmo_hit;

`ifdef AXIS_PKT_FRAMER_KEEPCLOSE_EN
  assign keep_close = (s_axis_tkeep != KEEP_FULL);
`else
  assign keep_close = 1'b0;
`endif

  assign o_free        = !o_vld_q || m_axis_tready;
  assign s_axis_tready = s_arstn && (!h_vld_q || o_free);
  assign accept        = s_axis_tvalid && s_axis_tready;
  // A held word leaves only when pushed out by a successor or once it is known to be last
  assign move_h        = h_vld_q && o_free && (accept || h_last_q);
  assign eff_len       = (wcnt_q == '0) ? cfg_pkt_len : len_q;
  assign new_last      = (wcnt_q == eff_len) || flush || keep_close;

  always_comb begin
    h_data_d  = h_data_q;
    h_keep_d  = h_keep_q;
    h_vld_d   = h_vld_q;
    h_last_d  = h_last_q;
    o_data_d  = o_data_q;
    o_keep_d  = o_keep_q;
    o_vld_d   = o_vld_q;
    o_last_d  = o_last_q;
    wcnt_d    = wcnt_q;
    len_d     = len_q;
    pkt_cnt_d = pkt_cnt_q;

    if (move_h) begin
      o_data_d = h_data_q;
      o_keep_d = h_keep_q;
      o_last_d = h_last_q;
      o_vld_d  = 1'b1;
    end else if (o_free) begin
      o_vld_d = 1'b0;
    end

    if (accept) begin
      h_data_d = s_axis_tdata;
      h_keep_d = s_axis_tkeep;
      h_vld_d  = 1'b1;
      h_last_d = new_last;
      wcnt_d   = new_last ? '0 : wcnt_q + LEN_BITS'(1);
      if (wcnt_q == '0) len_d = cfg_pkt_len;
    end else if (move_h) begin
      h_vld_d  = 1'b0;
      h_last_d = 1'b0;
    end else if (h_vld_q && !h_last_q && (tmo_hit || flush)) begin
      h_last_d = 1'b1;
      wcnt_d   = '0;
    end

    if (o_vld_q && m_axis_tready && o_last_q) pkt_cnt_d = pkt_cnt_q + 32'd1;
  end

  always_ff @(posedge s_axis_clk or negedge s_arstn) begin
    if (!s_arstn) begin
      h_data_q  <= '0;
      h_keep_q  <= '0;
      h_vld_q   <= 1'b0;
      h_last_q  <= 1'b0;
      o_data_q  <= '0;
      o_keep_q  <= '0;
      o_vld_q   <= 1'b0;
      o_last_q  <= 1'b0;
      wcnt_q    <= '0;
      len_q     <= '0;
      pkt_cnt_q <= '0;
    end else begin
      h_data_q  <= h_data_d;
      h_keep_q  <= h_keep_d;
      h_vld_q   <= h_vld_d;
      h_last_q  <= h_last_d;
      o_data_q  <= o_data_d;
      o_keep_q  <= o_keep_d;
      o_vld_q   <= o_vld_d;
      o_last_q  <= o_last_d;
      wcnt_q    <= wcnt_d;
      len_q     <= len_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  axis_pkt_framer_tmo #(.TMO_BITS(TMO_BITS)) u_tmo (
    .clk          (s_axis_clk),
    .rst_n        (s_arstn),
    .cfg_timeout  (cfg_timeout),
    .accept       (accept),
    .armed        (h_vld_q && !h_last_q),
    .tmo_hit      (tmo_hit),
    .stat_tmo_cnt (stat_tmo_cnt)
  );

  assign m_axis_tdata  = o_data_q;
  assign m_axis_tkeep  = o_keep_q;
  assign m_axis_tlast  = o_last_q;
  assign m_axis_tvalid = o_vld_q;
  assign stat_pkt_cnt  = pkt_cnt_q;

endmodule
